svga_layer_sched: RTL
=====================

# svga_layer_sched

Four-layer window scheduler for the 800x600 SVGA pixel path. It takes the pixel coordinates and pixel-valid from the SVGA timing generator and produces the per-source enables (a..d) that drive the display source mux. It double-buffers the window configuration so changes take effect at a frame boundary. Once per active line, it sequences line-fetch requests for the layers that cover the next line, using a req/ack handshake to the frame-memory reader.

## Interface
Parameters:
- H_MAX, 799, last active pixel column
- V_MAX, 599, last active line
- NL, 4, number of layers (fixed at 4; index 0 = source a)

Ports:
- clk  in  1  pixel clock
- rstb  in  1  reset; asynchronous, active-low
- h_c  in  10  current pixel column from timing generator
- v_c  in  10  current pixel line from timing generator
- h_c_en  in  1  h_c/v_c valid (active pixel)
- cfg_we  in  1  config write strobe, one cycle
- cfg_addr  in  5  config register address
- cfg_wdata  in  10  config write data
- lay_en  out  4  per-layer enable; bit0..3 drive in_a..in_d_da_en
- fetch_req  out  1  line-fetch request
- fetch_layer  out  2  layer index of the current request
- fetch_line  out  10  line number to fetch
- fetch_ack  in  1  fetch accepted (sampled only while fetch_req=1)
- busy  out  1  fetch sequencer not idle
- ovf  out  1  sticky overrun flag

## Operation
- Shadow registers, written by cfg_we:
  - addr 4*L+0 = x_start[L], 4*L+1 = x_end[L], 4*L+2 = y_start[L], 4*L+3 = y_end[L] (L=0..3).
  - addr 16 = enable[3:0] from cfg_wdata[3:0]; also sets commit_pend.
  - addr 17 = clears ovf.
  - Other addresses are ignored.
- Active registers: shadow is copied to active on the frame-end event (h_c_en=1, h_c=H_MAX, v_c=V_MAX) when commit_pend=1; commit_pend clears on the copy. Writes to the coordinate registers alone never commit.
- Window hit for layer L: active enable[L] & x_start<=h_c<=x_end & y_start<=v_c<=y_end, using inclusive 10-bit unsigned compares. If start>end, the layer never hits.
- lay_en[L] = registered hit when h_c_en=1; lay_en=0 when h_c_en=0. Several bits may be set; the downstream mux resolves priority a>b>c>d.
- next_line = (v_c==V_MAX) ? 0 : v_c+1.
- Line-end event: h_c_en=1 and h_c=H_MAX.
- Fetch FSM states:
  - IDLE: on a line-end event, latch nl=next_line and go to EVAL.
  - EVAL (1 cycle): pending[3:0] = active enable & y_start<=nl<=y_end per layer. If pending=0 go to IDLE, else go to REQ.
  - REQ: drive fetch_req=1 with fetch_layer = lowest set pending bit and fetch_line=nl. Outputs are held stable until fetch_ack=1. On ack, clear that pending bit and drop req for one cycle (GAP).
  - GAP: if pending=0 go to IDLE, else go to REQ.
- busy=1 in EVAL/REQ/GAP.
- Line-end event while busy:
  - Set ovf.
  - An outstanding REQ still completes on ack; the remaining old pending bits are discarded.
  - Latch the new nl, then go to EVAL after the current ack (directly, if in GAP).
  - Repeated events before the ack keep only the newest nl.
- Reset mid-operation: all state cleared immediately; fetch_req drops asynchronously.

## Timing
- Reset values:
  - lay_en=0, fetch_req=0, fetch_layer=0, fetch_line=0, busy=0, ovf=0.
  - All shadow and active registers = 0; commit_pend=0.
- lay_en latency: 1 cycle after the h_c/v_c/h_c_en sample, which aligns with the timing generator's display-enable delay.
- Commit: new config applies from pixel (0,0) of the frame following the frame-end copy.
- Simultaneous events:
  - A cfg write on the frame-end cycle updates shadow, but the copy uses the pre-write shadow. A write to addr 16 on that cycle leaves commit_pend=1.
  - A cfg write to 17 coincident with an overrun leaves ovf=1.
- First fetch_req: 2 cycles after the line-end event (IDLE->EVAL->REQ), using post-commit active regs for line 0.
- Minimum request spacing: ack cycle + 1 GAP cycle.

## Test plan
- Layer0 window x 100..199, y 50..59, enable=1, commit → lay_en[0]=1 for exactly 100 pixels per line on lines 50..59 only, 1 cycle after h_c=100; all other bits 0.
- Layers 0 and 2 covering line 10, ack after 3 cycles each → at the line-end of line 9: req layer0 line10, GAP, then req layer2 line10, then IDLE; busy falls after the second ack.
- Line-end at v_c=599 with layer covering y 0..0 → fetch_line=0.
- Hold fetch_ack=0 across two line-ends → ovf=1; after the ack, only the newest line is fetched; a write to addr 17 clears ovf.
- Coordinate write mid-frame without addr 16 → lay_en unchanged; with addr 16 → change visible starting at (0,0) of the next frame; x_start=300, x_end=200 → never enabled.
- Assert rstb low while fetch_req=1 → all outputs 0 immediately; no request after release until the next line-end event.

Source files
------------

// File: rtl/svga_layer_sched.sv
// svga_layer_sched: per-pixel window enables for four display layers and a per-line
// fetch-request sequencer toward the frame-memory reader. Rev 1.0
`default_nettype none

module svga_layer_sched #(
  parameter int H_MAX = 799,
  parameter int V_MAX = 599,
  parameter int NL    = 4
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic [9:0] h_c,
  input  logic [9:0] v_c,
  input  logic       h_c_en,
  input  logic       cfg_we,
  input  logic [4:0] cfg_addr,
  input  logic [9:0] cfg_wdata,
  output logic [3:0] lay_en,
  output logic       fetch_req,
  output logic [1:0] fetch_layer,
  output logic [9:0] fetch_line,
  input  logic       fetch_ack,
  output logic       busy,
  output logic       ovf
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_REQ, S_GAP} state_t;

  logic [9:0] xs_s [NL];
  logic [9:0] xe_s [NL];
  logic [9:0] ys_s [NL];
  logic [9:0] ye_s [NL];
  logic [9:0] xs_a [NL];
  logic [9:0] xe_a [NL];
  logic [9:0] ys_a [NL];
  logic [9:0] ye_a [NL];
  logic [3:0] en_s, en_a;
  logic       commit_pend;

  logic       line_end, frame_end;
  logic [9:0] next_line;
  logic [3:0] pix_hit, line_hit;

  state_t     state, state_nx;
  logic [9:0] nl, nl_nx, nl_new, nl_new_nx;
  logic       again, again_nx;
  logic [3:0] pending, pend_nx, low_onehot;
  logic [1:0] cur_layer;

  assign line_end  = h_c_en && (h_c == 10'(H_MAX));
  assign frame_end = line_end && (v_c == 10'(V_MAX));
  assign next_line = (v_c == 10'(V_MAX)) ? 10'd0 : v_c + 10'd1;

  // The frame-end copy reads the pre-write shadow; an addr-16 write on that cycle re-arms the commit.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < NL; i++) begin
        xs_s[i] <= '0; xe_s[i] <= '0; ys_s[i] <= '0; ye_s[i] <= '0;
        xs_a[i] <= '0; xe_a[i] <= '0; ys_a[i] <= '0; ye_a[i] <= '0;
      end
      en_s        <= '0;
      en_a        <= '0;
      commit_pend <= 1'b0;
    end else begin
      if (frame_end && commit_pend) begin
        xs_a        <= xs_s;
        xe_a        <= xe_s;
        ys_a        <= ys_s;
        ye_a        <= ye_s;
        en_a        <= en_s;
        commit_pend <= 1'b0;
      end
      if (cfg_we) begin
        if (!cfg_addr[4]) begin
          case (cfg_addr[1:0])
            2'd0:    xs_s[cfg_addr[3:2]] <= cfg_wdata;
            2'd1:    xe_s[cfg_addr[3:2]] <= cfg_wdata;
            2'd2:    ys_s[cfg_addr[3:2]] <= cfg_wdata;
            default: ye_s[cfg_addr[3:2]] <= cfg_wdata;
          endcase
        end else if (cfg_addr == 5'd16) begin
          en_s        <= cfg_wdata[3:0];
          commit_pend <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    pix_hit  = '0;
    line_hit = '0;
    for (int i = 0; i < NL; i++) begin
      pix_hit[i]  = en_a[i] && (xs_a[i] <= h_c) && (h_c <= xe_a[i]) &&
                    (ys_a[i] <= v_c) && (v_c <= ye_a[i]);
      line_hit[i] = en_a[i] && (ys_a[i] <= nl) && (nl <= ye_a[i]);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) lay_en <= '0;
    else       lay_en <= h_c_en ? pix_hit : 4'd0;
  end

  always_comb begin
    cur_layer = 2'd0;
    for (int i = NL - 1; i >= 0; i--) begin
      if (pending[i]) cur_layer = 2'(i);
    end
    low_onehot = 4'b0001 << cur_layer;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= S_IDLE;
      nl      <= '0;
      nl_new  <= '0;
      again   <= 1'b0;
      pending <= '0;
    end else begin
      state   <= state_nx;
      nl      <= nl_nx;
      nl_new  <= nl_new_nx;
      again   <= again_nx;
      pending <= pend_nx;
    end
  end

  // An overrun during REQ parks the newest line in nl_new so fetch_line stays stable until the ack.
  always_comb begin
    state_nx  = state;
    nl_nx     = nl;
    nl_new_nx = nl_new;
    again_nx  = again;
    pend_nx   = pending;
    case (state)
      S_IDLE: begin
        if (line_end) begin
          nl_nx    = next_line;
          state_nx = S_EVAL;
        end
      end
      S_EVAL: begin
        if (line_end) begin
          nl_nx = next_line;
        end else begin
          pend_nx  = line_hit;
          state_nx = (|line_hit) ? S_REQ : S_IDLE;
        end
      end
      S_REQ: begin
        if (line_end) begin
          nl_new_nx = next_line;
          again_nx  = 1'b1;
        end
        if (fetch_ack) begin
          pend_nx = pending & ~low_onehot;
          if (line_end) begin
            nl_nx    = next_line;
            again_nx = 1'b0;
            state_nx = S_EVAL;
          end else if (again) begin
            nl_nx    = nl_new;
            again_nx = 1'b0;
            state_nx = S_EVAL;
          end else begin
            state_nx = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (line_end) begin
          nl_nx    = next_line;
          state_nx = S_EVAL;
        end else begin
          state_nx = (|pending) ? S_REQ : S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)                               ovf <= 1'b0;
    else if (line_end && busy)               ovf <= 1'b1;
    else if (cfg_we && cfg_addr == 5'd17)    ovf <= 1'b0;
  end

  assign busy        = (state != S_IDLE);
  assign fetch_req   = (state == S_REQ);
  assign fetch_layer = cur_layer;
  assign fetch_line  = nl;

endmodule

`default_nettype wire
